// File: rtl/param_digit_counter_pkg.sv
// Shared constants and helpers for the cascaded digit counter.
package param_digit_counter_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Saturate an out-of-range nibble to the largest legal digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input int unsigned radix);
        if (32'(d) >= radix) begin
            return DIGIT_W'(radix - 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/param_digit_counter_digit_cell.sv
// One counter digit: registered value, wrap on inc/dec, ripple carry/borrow, clamped load.
module digit_cell
    import param_digit_counter_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               cin,
    input  dir_e               dir,
    output logic [DIGIT_W-1:0] value,
    output logic               cout_c
);

    localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

    // Pass the step upward when this digit is about to wrap in the current direction.
    assign cout_c = cin & ((dir == DIR_UP) ? (value == MAX) : (value == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= clamp_digit(load_digit, RADIX);
        end else if (cin) begin
            if (dir == DIR_UP) begin
                value <= (value == MAX) ? '0 : value + DIGIT_W'(1);
            end else begin
                value <= (value == '0) ? MAX : value - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/param_digit_counter.sv
// Prescaled up/down counter of DIGITS cascaded radix-RADIX digits with load and wrap pulse.
module param_digit_counter
    import param_digit_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned DIV    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sel,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_value,
    output logic [DIGIT_W*DIGITS-1:0]   digits,
    output logic                        tick,
    output logic                        carry_out
);

    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             step_c;
    logic [DIGITS:0]  chain;

    assign step_c   = en & ~load & (pre == PRE_MAX);
    assign chain[0] = step_c;

    // Prescaler: counts enabled cycles, cleared by load so the next step is a full DIV away.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            tick      <= step_c;
            carry_out <= chain[DIGITS];
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_cell #(
            .RADIX(RADIX)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_value[i*DIGIT_W +: DIGIT_W]),
            .cin        (chain[i]),
            .dir        (dir_e'(sel)),
            .value      (digits[i*DIGIT_W +: DIGIT_W]),
            .cout_c     (chain[i+1])
        );
    end

endmodule
